// File: rtl/mesi_isc_breq_arb.sv
// mesi_isc_breq_arb: per-CPU broadcast request queues feeding
// the shared broadcast FIFO through a round-robin issuer.
module mesi_isc_breq_arb #(
  parameter int ADDR_WIDTH          = 32,
  parameter int MBUS_CMD_WIDTH      = 3,
  parameter int BROAD_TYPE_WIDTH    = 2,
  parameter int BROAD_ID_WIDTH      = 5,
  parameter int BREQ_FIFO_SIZE      = 2,
  parameter int BREQ_FIFO_SIZE_LOG2 = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
  input  logic [4*ADDR_WIDTH-1:0]     mbus_addr_array_i,
  input  logic                        fifo_status_full_i,
  output logic [3:0]                  mbus_ack_array_o,
  output logic                        broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]       broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0] broad_type_o,
  output logic [1:0]                  broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]   broad_id_o
);

  localparam int EW = ADDR_WIDTH + BROAD_TYPE_WIDTH;
  localparam int PW = (BREQ_FIFO_SIZE_LOG2 > 0) ?
                      BREQ_FIFO_SIZE_LOG2 : 1;
  localparam int CW = PW + 1;

  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR =
    MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD =
    MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR =
    BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD =
    BROAD_TYPE_WIDTH'(2);

  typedef logic [EW-1:0] entry_t;

  entry_t                    mem   [4][BREQ_FIFO_SIZE];
  logic [PW-1:0]             wptr  [4];
  logic [PW-1:0]             rptr  [4];
  logic [CW-1:0]             cnt   [4];
  entry_t                    entry [4];
  entry_t                    head  [4];
  logic [3:0]                push;
  logic [3:0]                pop;
  logic [3:0]                full;
  logic [3:0]                empty;
  logic [1:0]                rr_ptr;
  logic [1:0]                gnt;
  logic [1:0]                idx;
  logic                      found;
  logic                      issue;
  logic [BROAD_ID_WIDTH-1:0] id_cnt;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(BREQ_FIFO_SIZE - 1)) ?
           '0 : p + PW'(1);
  endfunction

  // Decode each CPU's command and decide whether it is taken now.
  always_comb begin
    logic [MBUS_CMD_WIDTH-1:0] cmd_n;
    logic                      is_wr;
    logic                      is_rd;
    cmd_n = '0;
    is_wr = 1'b0;
    is_rd = 1'b0;
    push  = '0;
    full  = '0;
    empty = '0;
    for (int n = 0; n < 4; n++) begin
      cmd_n = mbus_cmd_array_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      is_wr = (cmd_n == CMD_WR);
      is_rd = (cmd_n == CMD_RD);
      entry[n] = {
        mbus_addr_array_i[n*ADDR_WIDTH +: ADDR_WIDTH],
        is_wr ? TYPE_WR : TYPE_RD
      };
      full[n]  = (cnt[n] == CW'(BREQ_FIFO_SIZE));
      empty[n] = (cnt[n] == '0);
      // The ack cycle masks a held command so it is taken once.
      push[n]  = (is_wr | is_rd) & ~full[n] &
                 ~mbus_ack_array_o[n];
      head[n]  = mem[n][rptr[n]];
    end
  end

  // Round-robin search from rr_ptr over queues non-empty now.
  always_comb begin
    gnt   = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && !empty[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
    // Gap after every write keeps the downstream FIFO safe.
    issue = found & ~fifo_status_full_i & ~broad_fifo_wr_o;
    pop   = '0;
    if (issue) pop[gnt] = 1'b1;
  end

  // Queue storage; contents need no reset, pointers guard them.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) mem[n][wptr[n]] <= entry[n];
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
        cnt[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) wptr[n] <= ptr_inc(wptr[n]);
        if (pop[n])  rptr[n] <= ptr_inc(rptr[n]);
        case ({push[n], pop[n]})
          2'b10:   cnt[n] <= cnt[n] + CW'(1);
          2'b01:   cnt[n] <= cnt[n] - CW'(1);
          default: cnt[n] <= cnt[n];
        endcase
      end
    end
  end

  // One-cycle accept pulse per CPU.
  always_ff @(posedge clk) begin
    if (rst) mbus_ack_array_o <= '0;
    else     mbus_ack_array_o <= push;
  end

  // Broadcast issue: registered outputs hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      broad_fifo_wr_o <= 1'b0;
      broad_addr_o    <= '0;
      broad_type_o    <= '0;
      broad_cpu_id_o  <= '0;
      broad_id_o      <= '0;
      id_cnt          <= '0;
      rr_ptr          <= '0;
    end else begin
      broad_fifo_wr_o <= issue;
      if (issue) begin
        broad_addr_o   <= head[gnt][EW-1:BROAD_TYPE_WIDTH];
        broad_type_o   <= head[gnt][BROAD_TYPE_WIDTH-1:0];
        broad_cpu_id_o <= gnt;
        broad_id_o     <= id_cnt;
        id_cnt         <= id_cnt + BROAD_ID_WIDTH'(1);
        rr_ptr         <= gnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// tb_mesi_isc_breq_arb: randomized and directed scenarios checked
// against a queue-based transaction model of the arbiter.
module tb_mesi_isc_breq_arb;

  logic        clk;
  logic        rst;
  logic        full_in;
  logic [2:0]  cmd_in  [4];
  logic [31:0] addr_in [4];
  logic [11:0] mbus_cmd_array_i;
  logic [127:0] mbus_addr_array_i;
  logic [3:0]  mbus_ack_array_o;
  logic        broad_fifo_wr_o;
  logic [31:0] broad_addr_o;
  logic [1:0]  broad_type_o;
  logic [1:0]  broad_cpu_id_o;
  logic [4:0]  broad_id_o;

  int checks = 0;
  int errors = 0;

  assign mbus_cmd_array_i =
    {cmd_in[3], cmd_in[2], cmd_in[1], cmd_in[0]};
  assign mbus_addr_array_i =
    {addr_in[3], addr_in[2], addr_in[1], addr_in[0]};

  mesi_isc_breq_arb dut (
    .clk                (clk),
    .rst                (rst),
    .mbus_cmd_array_i   (mbus_cmd_array_i),
    .mbus_addr_array_i  (mbus_addr_array_i),
    .fifo_status_full_i (full_in),
    .mbus_ack_array_o   (mbus_ack_array_o),
    .broad_fifo_wr_o    (broad_fifo_wr_o),
    .broad_addr_o       (broad_addr_o),
    .broad_type_o       (broad_type_o),
    .broad_cpu_id_o     (broad_cpu_id_o),
    .broad_id_o         (broad_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  t;
  } ent_t;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
  } req_t;

  typedef struct packed {
    logic [1:0]  c;
    logic [4:0]  i;
    logic [31:0] a;
    logic [1:0]  t;
  } bc_t;

  // Reference model state.
  ent_t        mq [4][$];
  logic [3:0]  e_ack;
  logic        e_wr;
  logic [31:0] e_addr;
  logic [1:0]  e_type;
  logic [1:0]  e_cpu;
  logic [4:0]  e_id;
  int          nid;
  int          rr;
  bit          acc_evt [4];

  // Stimulus and observation state.
  req_t        pend [4][$];
  int          held [4];
  logic [3:0]  ack_log [$];
  logic        wr_log [$];
  bc_t         blog [$];

  // Model: one broadcast per free slot, queues of depth 2,
  // next-in-line priority after each grant.
  always @(posedge clk) begin
    int g;
    logic [3:0] na;
    ent_t h;
    if (rst) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      e_ack = '0; e_wr = 1'b0; e_addr = '0;
      e_type = '0; e_cpu = '0; e_id = '0;
      nid = 0; rr = 0;
    end else begin
      g = -1;
      if (!full_in && !e_wr) begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && mq[(rr + k) % 4].size() > 0)
            g = (rr + k) % 4;
      end
      for (int n = 0; n < 4; n++)
        na[n] = (cmd_in[n] == 3'd3 || cmd_in[n] == 3'd4) &&
                mq[n].size() < 2 && !e_ack[n];
      e_wr = (g >= 0);
      if (g >= 0) begin
        h = mq[g].pop_front();
        e_addr = h.a; e_type = h.t;
        e_cpu = 2'(g); e_id = 5'(nid);
        nid = (nid + 1) % 32;
        rr = (g + 1) % 4;
      end
      for (int n = 0; n < 4; n++) begin
        if (na[n]) begin
          h.a = addr_in[n];
          h.t = (cmd_in[n] == 3'd3) ? 2'd1 : 2'd2;
          mq[n].push_back(h);
          acc_evt[n] = 1'b1;
        end
      end
      e_ack = na;
    end
  end

  function automatic logic [45:0] dut_vec();
    return {mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o,
            broad_type_o, broad_cpu_id_o, broad_id_o};
  endfunction

  function automatic logic [45:0] exp_vec();
    return {e_ack, e_wr, e_addr, e_type, e_cpu, e_id};
  endfunction

  function automatic bit busy();
    bit b;
    b = e_wr || (e_ack != 4'd0);
    for (int n = 0; n < 4; n++)
      if (pend[n].size() > 0 || mq[n].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic int ack_count(input int n);
    int k;
    k = 0;
    foreach (ack_log[i]) if (ack_log[i][n] === 1'b1) k++;
    return k;
  endfunction

  task automatic clear_logs();
    ack_log.delete();
    wr_log.delete();
    blog.delete();
  endtask

  task automatic observe();
    bc_t b;
    ack_log.push_back(mbus_ack_array_o);
    wr_log.push_back(broad_fifo_wr_o);
    if (broad_fifo_wr_o === 1'b1) begin
      b.c = broad_cpu_id_o; b.i = broad_id_o;
      b.a = broad_addr_o;   b.t = broad_type_o;
      blog.push_back(b);
    end
  endtask

  // CPU side: present the head request, advance after its accept.
  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      if (acc_evt[n]) begin
        acc_evt[n] = 1'b0;
        if (pend[n].size() > 0) void'(pend[n].pop_front());
        held[n] = 0;
      end else if (pend[n].size() > 0 && held[n] >= 2 &&
                   !(pend[n][0].c inside {3'd3, 3'd4})) begin
        void'(pend[n].pop_front());
        held[n] = 0;
      end
      if (pend[n].size() > 0) begin
        cmd_in[n]  = pend[n][0].c;
        addr_in[n] = pend[n][0].a;
        held[n]++;
      end else begin
        cmd_in[n]  = 3'd0;
        addr_in[n] = $urandom;
      end
    end
  endtask

  task automatic add_req(input int n, input logic [2:0] c,
                         input logic [31:0] a);
    req_t r;
    r.c = c; r.a = a;
    pend[n].push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    full_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pend[n].delete();
      cmd_in[n] = 3'd0;
      held[n] = 0;
      acc_evt[n] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    full_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 4; n++) begin
        cmd_in[n]  = 3'($urandom_range(3, 4));
        addr_in[n] = $urandom;
      end
      @(negedge clk);
      checks++;
      if (dut_vec() !== 46'd0) begin
        errors++;
        $display("FAIL reset_outs cyc%0d got %h exp 0",
                 c, dut_vec());
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cmd_in[n] = 3'd0; acc_evt[n] = 1'b0; held[n] = 0;
    end
    clear_logs();
    add_req(0, 3'd3, 32'h0000_0055);
    drive();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    checks++;
    if (blog.size() != 1 || blog[0].i !== 5'd0) begin
      errors++;
      $display("FAIL reset_first_id got n=%0d id=%0d exp n=1 id=0",
               blog.size(), blog.size() ? blog[0].i : 5'h1f);
    end
  endtask

  task automatic test_single();
    bc_t x;
    do_reset();
    add_req(2, 3'd4, 32'h0000_1000);
    drive();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    checks++;
    if (ack_log[0] !== 4'b0100 || ack_log[1] !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack got %b,%b exp 0100,0000",
               ack_log[0], ack_log[1]);
    end
    checks++;
    if (wr_log[0] !== 1'b0 || wr_log[1] !== 1'b1) begin
      errors++;
      $display("FAIL single_wr_lat got %b,%b exp 0,1",
               wr_log[0], wr_log[1]);
    end
    x.c = 2'd2; x.i = 5'd0; x.a = 32'h0000_1000; x.t = 2'd2;
    checks++;
    if (blog.size() != 1 || blog[0] !== x) begin
      errors++;
      $display("FAIL single_bcast got n=%0d %h exp n=1 %h",
               blog.size(), blog.size() ? blog[0] : '0, x);
    end
  endtask

  task automatic test_all_four();
    int wc [$];
    do_reset();
    for (int n = 0; n < 4; n++)
      add_req(n, 3'd3, 32'hA000_0000 | 32'(n));
    drive();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL four_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    foreach (wr_log[i]) if (wr_log[i] === 1'b1) wc.push_back(i);
    checks++;
    if (blog.size() != 4 || wc.size() != 4) begin
      errors++;
      $display("FAIL four_count got %0d exp 4", blog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (blog[i].c !== 2'(i) || blog[i].i !== 5'(i) ||
            blog[i].t !== 2'd1 ||
            blog[i].a !== (32'hA000_0000 | 32'(i)) ||
            wc[i] != 1 + 2 * i) begin
          errors++;
          $display("FAIL four_b%0d got %h@%0d exp cpu%0d id%0d @%0d",
                   i, blog[i], wc[i], i, i, 1 + 2 * i);
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    int k;
    do_reset();
    full_in = 1'b1;
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 3; j++)
        add_req(n, 3'd3, 32'h100 * n + 32'(j));
    drive();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ack_count(n) != 2) begin
        errors++;
        $display("FAIL full_acks cpu%0d got %0d exp 2",
                 n, ack_count(n));
      end
    end
    checks++;
    if (blog.size() != 0) begin
      errors++;
      $display("FAIL full_no_wr got %0d exp 0", blog.size());
    end
    full_in = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    checks++;
    if (busy() || blog.size() != 12) begin
      errors++;
      $display("FAIL full_total got %0d exp 12", blog.size());
    end
    for (int n = 0; n < 4; n++) begin
      k = 0;
      foreach (blog[i]) begin
        if (blog[i].c == 2'(n)) begin
          checks++;
          if (blog[i].a !== 32'h100 * n + 32'(k)) begin
            errors++;
            $display("FAIL full_order cpu%0d got %h exp %h",
                     n, blog[i].a, 32'h100 * n + 32'(k));
          end
          k++;
        end
      end
      checks++;
      if (ack_count(n) != 3) begin
        errors++;
        $display("FAIL full_held_ack cpu%0d got %0d exp 3",
                 n, ack_count(n));
      end
    end
    foreach (blog[i]) begin
      checks++;
      if (blog[i].i !== 5'(i)) begin
        errors++;
        $display("FAIL full_id b%0d got %0d exp %0d",
                 i, blog[i].i, i);
      end
    end
  endtask

  task automatic test_id_wrap_illegal();
    logic [31:0] ea [$];
    logic [31:0] a;
    do_reset();
    for (int j = 0; j < 33; j++) begin
      a = $urandom;
      ea.push_back(a);
      add_req(1, ($urandom % 2) ? 3'd3 : 3'd4, a);
    end
    add_req(3, 3'd1, 32'h3333_0001);
    add_req(3, 3'd7, 32'h3333_0007);
    drive();
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    checks++;
    if (busy() || blog.size() != 33) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 33", blog.size());
    end else begin
      for (int i = 0; i < 33; i++) begin
        checks++;
        if (blog[i].i !== 5'(i % 32) || blog[i].c !== 2'd1 ||
            blog[i].a !== ea[i]) begin
          errors++;
          $display("FAIL wrap_b%0d got id%0d cpu%0d exp id%0d cpu1",
                   i, blog[i].i, blog[i].c, i % 32);
        end
      end
    end
    checks++;
    if (ack_count(3) != 0 || ack_count(1) != 33) begin
      errors++;
      $display("FAIL wrap_acks got cpu3=%0d cpu1=%0d exp 0,33",
               ack_count(3), ack_count(1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    full_in = 1'b1;
    for (int j = 0; j < 3; j++) add_req(0, 3'd4, 32'h10 + 32'(j));
    for (int j = 0; j < 2; j++) add_req(1, 3'd3, 32'h20 + 32'(j));
    add_req(2, 3'd4, 32'h30);
    drive();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
    end
    rst = 1'b1;
    full_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pend[n].delete();
      cmd_in[n] = 3'd0; held[n] = 0; acc_evt[n] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (dut_vec() !== 46'd0) begin
      errors++;
      $display("FAIL mid_rst_outs got %h exp 0", dut_vec());
    end
    rst = 1'b0;
    clear_logs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_idle cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
    end
    checks++;
    if (blog.size() != 0 || ack_log.sum() with (32'(item)) != 0) begin
      errors++;
      $display("FAIL mid_quiet got wr=%0d exp 0", blog.size());
    end
    clear_logs();
    add_req(3, 3'd4, 32'hDEAD_0000);
    drive();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_after cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      drive();
      if (!busy()) break;
    end
    checks++;
    if (blog.size() != 1 || blog[0].i !== 5'd0 ||
        blog[0].c !== 2'd3) begin
      errors++;
      $display("FAIL mid_next_id got n=%0d exp n=1 id0 cpu3",
               blog.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] ea [4][$];
    logic [31:0] a;
    logic [2:0]  c3;
    int r;
    int k;
    int total;
    do_reset();
    total = 0;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 20; j++) begin
        r = $urandom % 10;
        a = $urandom;
        if (r < 4)      c3 = 3'd3;
        else if (r < 8) c3 = 3'd4;
        else if (r == 8) c3 = 3'($urandom_range(5, 7));
        else            c3 = 3'($urandom_range(1, 2));
        add_req(n, c3, a);
        if (c3 == 3'd3 || c3 == 3'd4) begin
          ea[n].push_back(a);
          total++;
        end
      end
    end
    drive();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_model cyc%0d got %h exp %h",
                 c, dut_vec(), exp_vec());
      end
      observe();
      full_in = ($urandom % 3 == 0);
      drive();
      if (!busy()) break;
    end
    full_in = 1'b0;
    checks++;
    if (busy() || blog.size() != total) begin
      errors++;
      $display("FAIL rand_total got %0d exp %0d",
               blog.size(), total);
    end
    for (int n = 0; n < 4; n++) begin
      k = 0;
      foreach (blog[i]) begin
        if (blog[i].c == 2'(n)) begin
          checks++;
          if (k >= ea[n].size() || blog[i].a !== ea[n][k]) begin
            errors++;
            $display("FAIL rand_order cpu%0d n%0d got %h",
                     n, k, blog[i].a);
          end
          k++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    full_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cmd_in[n] = 3'd0; addr_in[n] = '0;
      held[n] = 0; acc_evt[n] = 1'b0;
    end
    test_reset();
    test_single();
    test_all_four();
    test_full_backpressure();
    test_id_wrap_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
